// File: rtl/main_decoder_fsm.sv
// Multicycle main decoder: one state per cycle, Moore datapath strobes, ImmSrc/RegSrc decoded from Op/Funct.
// MemReady stalls FETCH/MEMREAD/MEMWRITE; MEM_TIMEOUT consecutive stalls trap to a sticky FAULT state.
module main_decoder_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] StateOut,
    output logic       Fault
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd15
    } state_t;

    localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             in_wait;
    logic             timeout;
    logic             unused_funct;

    assign unused_funct = ^Funct[4:1];

    assign in_wait = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    // MemReady wins over the limit: a completing access on the last allowed cycle never faults.
    assign timeout = TIMEOUT_EN && in_wait && !MemReady && (wait_cnt == CNT_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (MemReady)     state_next = DECODE;
                else if (timeout) state_next = FAULT;
            end
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FAULT;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (MemReady)     state_next = MEMWB;
                else if (timeout) state_next = FAULT;
            end
            MEMWB:    state_next = FETCH;
            MEMWRITE: begin
                if (MemReady)     state_next = FETCH;
                else if (timeout) state_next = FAULT;
            end
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            FAULT:    state_next = FAULT;
            default:  state_next = FETCH;
        endcase
    end

    // Counter only survives while parked in the same wait state with MemReady low; any entry or completion clears it.
    always_comb begin
        wait_cnt_next = '0;
        if (in_wait && !MemReady && (state_next == state)) begin
            wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ALUOp     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            MEMADR:   ALUSrcB = 2'd1;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'd1;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'd1;
                ALUOp   = 1'b1;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                Branch    = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence every write strobe immediately, before the state register catches up.
        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
        end
    end

    always_comb begin
        ImmSrc = 2'd0;
        RegSrc = 2'd0;
        case (Op)
            2'b01: begin
                ImmSrc = 2'd1;
                RegSrc = Funct[0] ? 2'd0 : 2'd2;
            end
            2'b10: begin
                ImmSrc = 2'd2;
                RegSrc = 2'd1;
            end
            default: ;
        endcase
    end

    assign StateOut = state;
    assign Fault    = (state == FAULT);

endmodule

// File: tb/tb_main_decoder_fsm.sv
// Randomised instruction-level bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_main_decoder_fsm;

    localparam int T = 4;

    localparam int S_FETCH = 0,  S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXR = 6, S_EXI = 7, S_ALUWB = 8, S_BRANCH = 9, S_FAULT = 15;

    typedef struct packed {
        logic [3:0] st;
        logic       irw;
        logic       npc;
        logic       regw;
        logic       memw;
        logic       br;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       aluop;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic       fault;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'd0;
    logic [5:0] Funct = 6'd0;
    logic       MemReady = 1'b0;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] StateOut;

    int   tests = 0;
    int   fails = 0;
    obs_t sb_q[$];

    main_decoder_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .StateOut(StateOut), .Fault(Fault)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_out(input int st, input bit mr, input bit rst,
                                       input logic [1:0] op, input logic [5:0] fn);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            S_FETCH:    begin o.srca = 2'd1; o.srcb = 2'd2; o.res = 2'd2; o.irw = mr; o.npc = mr; end
            S_DECODE:   begin o.srca = 2'd1; o.srcb = 2'd2; o.res = 2'd2; end
            S_MEMADR:   o.srcb = 2'd1;
            S_MEMREAD:  o.adr = 1'b1;
            S_MEMWB:    begin o.res = 2'd1; o.regw = 1'b1; end
            S_MEMWRITE: begin o.adr = 1'b1; o.memw = 1'b1; end
            S_EXR:      o.aluop = 1'b1;
            S_EXI:      begin o.srcb = 2'd1; o.aluop = 1'b1; end
            S_ALUWB:    o.regw = 1'b1;
            S_BRANCH:   begin o.srcb = 2'd1; o.res = 2'd2; o.br = 1'b1; end
            S_FAULT:    o.fault = 1'b1;
            default: ;
        endcase
        if (rst) begin
            o.irw = 1'b0; o.npc = 1'b0; o.regw = 1'b0; o.memw = 1'b0; o.br = 1'b0;
        end
        o.imm    = (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
        o.regsrc = (op == 2'd2) ? 2'd1 : (op == 2'd1 && !fn[0]) ? 2'd2 : 2'd0;
        return o;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what that cycle must show.
    task automatic cyc(input int st, input bit mr, input bit rst, input logic [1:0] op, input logic [5:0] fn);
        @(posedge clk);
        #1;
        Op = op; Funct = fn; MemReady = mr; reset = rst;
        sb_q.push_back(model_out(st, mr, rst, op, fn));
    endtask

    task automatic cyc_rand(input int st, input bit mr, input bit rst);
        cyc(st, mr, rst, 2'($urandom_range(0, 3)), 6'($urandom));
    endtask

    task automatic fault_seq();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) cyc_rand(S_FAULT, 1'($urandom), 1'b0);
        cyc_rand(S_FAULT, 1'($urandom), 1'b1);
    endtask

    // Instruction-level model: f_lo/m_lo are MemReady-low cycles before completion; T or more means timeout.
    task automatic do_instr(input logic [1:0] op, input logic [5:0] fn, input int f_lo, input int m_lo, input int rst_at);
        int ws;
        for (int i = 0; i < f_lo && i < T; i++) cyc_rand(S_FETCH, 1'b0, 1'b0);
        if (f_lo >= T) begin fault_seq(); return; end
        cyc_rand(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, 1'($urandom), 1'b0, op, fn);
        case (op)
            2'd0: begin
                cyc_rand(fn[5] ? S_EXI : S_EXR, 1'($urandom), 1'b0);
                cyc_rand(S_ALUWB, 1'($urandom), 1'b0);
            end
            2'd1: begin
                cyc(S_MEMADR, 1'($urandom), 1'b0, op, fn);
                ws = fn[0] ? S_MEMREAD : S_MEMWRITE;
                for (int i = 0; i < m_lo && i < T; i++) begin
                    if (i == rst_at) begin cyc(ws, 1'b0, 1'b1, op, fn); return; end
                    cyc(ws, 1'b0, 1'b0, op, fn);
                end
                if (m_lo >= T) begin fault_seq(); return; end
                cyc(ws, 1'b1, 1'b0, op, fn);
                if (fn[0]) cyc(S_MEMWB, 1'($urandom), 1'b0, op, fn);
            end
            2'd2: cyc(S_BRANCH, 1'($urandom), 1'b0, op, fn);
            default: fault_seq();
        endcase
    endtask

    always @(negedge clk) begin
        obs_t exp_o, act_o;
        if (sb_q.size() > 0) begin
            exp_o = sb_q.pop_front();
            act_o = '{StateOut, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, RegSrc, Fault};
            tests++;
            if (act_o !== exp_o) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t state got=%0d req=%0d vec got=%h req=%h",
                         $time, act_o.st, exp_o.st, act_o, exp_o);
            end
        end
    end

    initial begin
        int r, k, f_lo, m_lo, rst_at;
        logic [1:0] op;
        logic [5:0] fn;

        cyc_rand(S_FETCH, 1'b1, 1'b1);
        cyc_rand(S_FETCH, 1'b0, 1'b1);

        do_instr(2'd0, 6'b100000, 0, 0, -1);
        do_instr(2'd0, 6'b000000, 1, 0, -1);
        do_instr(2'd1, 6'b000001, 0, 3, -1);
        do_instr(2'd1, 6'b000000, 2, 2, -1);
        do_instr(2'd2, 6'b010101, 0, 0, -1);
        do_instr(2'd0, 6'b000000, 4, 0, -1);
        do_instr(2'd0, 6'b100000, 3, 0, -1);
        do_instr(2'd3, 6'b000000, 0, 0, -1);
        do_instr(2'd1, 6'b000000, 0, 3, 1);
        do_instr(2'd1, 6'b000001, 0, 4, -1);
        do_instr(2'd1, 6'b000000, 0, 4, -1);

        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 15);
            op = (r == 0) ? 2'd3 : 2'(r % 3);
            fn = 6'($urandom);
            k  = $urandom_range(0, 19);
            f_lo = (k < 17) ? k % 4 : 4 + k % 2;
            k  = $urandom_range(0, 19);
            m_lo = (k < 17) ? k % 4 : 4 + k % 2;
            rst_at = -1;
            if (op == 2'd1 && !fn[0] && m_lo > 0 && m_lo < T && $urandom_range(0, 7) == 0)
                rst_at = $urandom_range(0, m_lo - 1);
            do_instr(op, fn, f_lo, m_lo, rst_at);
        end

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d req=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
